// File: rtl/micro_tile_pkg.sv
// micro_tile_pkg
//   Shared definitions for the micro-tile scheduler.
//   - DEF_NUM_TILES / DEF_SEL_W : default tile count and select width
//   - tile_state_e              : scheduler FSM states
//   - onehot()                  : index to one-hot helper (callers truncate to their tile count)
package micro_tile_pkg;

  localparam int DEF_NUM_TILES = 4;
  localparam int DEF_SEL_W     = 2;
  localparam int MAX_TILES     = 32;

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    RUN      = 2'd1,
    GATE     = 2'd2
  } tile_state_e;

  function automatic logic [MAX_TILES-1:0] onehot(input logic [31:0] idx);
    onehot = MAX_TILES'(1) << idx;
  endfunction

endpackage

// File: rtl/pin_sync_debounce.sv
// pin_sync_debounce
//   Two-flop synchronizer followed by a stability timer for the raw select pins.
//   Ports:
//     clk, rst_n : clock, synchronous active-low reset
//     i_pin      : raw asynchronous pin field
//     o_value    : synchronized pin value
//     o_valid    : o_value has held for STABLE_CYC consecutive cycles
module pin_sync_debounce #(
  parameter int W          = 2,
  parameter int STABLE_CYC = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_pin,
  output logic [W-1:0] o_value,
  output logic         o_valid
);

  localparam int SC_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
  localparam logic [SC_W-1:0] STAB_LOAD = SC_W'(STABLE_CYC - 1);

  logic [W-1:0]    r_sync1;
  logic [W-1:0]    r_sync2;
  logic [SC_W-1:0] r_stab_cnt;

  // The timer reloads on the same edge that r_sync2 takes a new value, so the
  // cycle in which the new value first appears counts as its first stable cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stab_cnt <= STAB_LOAD;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      if (r_sync1 != r_sync2) begin
        r_stab_cnt <= STAB_LOAD;
      end else if (r_stab_cnt != '0) begin
        r_stab_cnt <= r_stab_cnt - SC_W'(1);
      end
    end
  end

  assign o_value = r_sync2;
  assign o_valid = (r_stab_cnt == '0);

endmodule

// File: rtl/micro_tile_sched.sv
// micro_tile_sched
//   Chooses the live micro tile and drives registered per-tile clock-enable,
//   reset and input-enable strobes. Every tile change runs GATE then RST_HOLD.
//   Ports:
//     clk, rst_n   : clock, synchronous active-low reset
//     sel_pin      : raw tile select pins (manual mode)
//     auto_en      : 1 = round-robin rotation, 0 = follow sel_pin
//     dwell        : RUN cycles per tile in auto mode, 0 = never rotate
//     tile_clk_en  : per-tile clock enable
//     tile_rst_n   : per-tile active-low reset
//     tile_in_en   : per-tile input pass enable
//     out_sel      : index of the tile driving the shared output
//     busy         : high whenever the scheduler is not in RUN
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RST_HOLD | active tile clocked with reset asserted, inputs blocked
//   RUN      | active tile fully enabled, switch requests evaluated
//   GATE     | every tile clock-gated and in reset before the new tile
module micro_tile_sched
  import micro_tile_pkg::*;
#(
  parameter int NUM_TILES  = DEF_NUM_TILES,
  parameter int SEL_W      = DEF_SEL_W,
  parameter int STABLE_CYC = 4,
  parameter int GATE_CYC   = 2,
  parameter int RST_CYC    = 8,
  parameter int DWELL_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SEL_W-1:0]     sel_pin,
  input  logic                 auto_en,
  input  logic [DWELL_W-1:0]   dwell,
  output logic [NUM_TILES-1:0] tile_clk_en,
  output logic [NUM_TILES-1:0] tile_rst_n,
  output logic [NUM_TILES-1:0] tile_in_en,
  output logic [SEL_W-1:0]     out_sel,
  output logic                 busy
);

  localparam int CNT_W = $clog2(RST_CYC + GATE_CYC + 1);
  localparam logic [CNT_W-1:0] GATE_LOAD = CNT_W'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(RST_CYC - 1);
  // Out of reset the hold is counted from the first released edge, so the
  // reset edge itself loads one extra cycle.
  localparam logic [CNT_W-1:0] BOOT_LOAD = CNT_W'(RST_CYC);

  tile_state_e          r_state;
  tile_state_e          w_next_state;
  logic [SEL_W-1:0]     r_active;
  logic [SEL_W-1:0]     w_next_active;
  logic [SEL_W-1:0]     r_target;
  logic [SEL_W-1:0]     w_next_target;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_next_cnt;
  logic [DWELL_W-1:0]   r_dwell_cnt;
  logic [DWELL_W-1:0]   w_next_dwell;
  logic [DWELL_W-1:0]   w_dwell_inc;

  logic [SEL_W-1:0]     w_acc_sel;
  logic                 w_acc_valid;

  logic [NUM_TILES-1:0] w_oh;
  logic [NUM_TILES-1:0] w_clk_en;
  logic [NUM_TILES-1:0] w_rst_n;
  logic [NUM_TILES-1:0] w_in_en;
  logic                 w_busy;

  logic [NUM_TILES-1:0] r_clk_en;
  logic [NUM_TILES-1:0] r_rst_n;
  logic [NUM_TILES-1:0] r_in_en;
  logic                 r_busy;

  pin_sync_debounce #(
    .W          (SEL_W),
    .STABLE_CYC (STABLE_CYC)
  ) u_pin_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_pin   (sel_pin),
    .o_value (w_acc_sel),
    .o_valid (w_acc_valid)
  );

  assign w_dwell_inc = r_dwell_cnt + DWELL_W'(1);

  always_comb begin
    w_next_state  = r_state;
    w_next_active = r_active;
    w_next_target = r_target;
    w_next_cnt    = r_cnt;
    w_next_dwell  = r_dwell_cnt;
    unique case (r_state)
      RST_HOLD: begin
        if (r_cnt == '0) begin
          w_next_state = RUN;
          w_next_dwell = '0;
        end else begin
          w_next_cnt = r_cnt - CNT_W'(1);
        end
      end
      RUN: begin
        if (auto_en) begin
          if (dwell == '0) begin
            w_next_dwell = '0;
          end else if (w_dwell_inc >= dwell) begin
            // >= rather than == so a dwell lowered mid-run cannot strand the counter
            w_next_state  = GATE;
            w_next_target = r_active + SEL_W'(1);
            w_next_cnt    = GATE_LOAD;
            w_next_dwell  = '0;
          end else begin
            w_next_dwell = w_dwell_inc;
          end
        end else begin
          // Manual mode keeps the counter at 0, which also clears it on any auto_en toggle.
          w_next_dwell = '0;
          if (w_acc_valid && (w_acc_sel != r_active)) begin
            w_next_state  = GATE;
            w_next_target = w_acc_sel;
            w_next_cnt    = GATE_LOAD;
          end
        end
      end
      GATE: begin
        if (r_cnt == '0) begin
          w_next_state  = RST_HOLD;
          w_next_active = r_target;
          w_next_cnt    = HOLD_LOAD;
        end else begin
          w_next_cnt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_next_state = RST_HOLD;
        w_next_cnt   = HOLD_LOAD;
      end
    endcase
  end

  // Strobes are decoded from the next state and registered, so every output
  // flips cleanly on the same edge as the state it belongs to.
  always_comb begin
    w_oh     = NUM_TILES'(onehot(32'(w_next_active)));
    w_clk_en = '0;
    w_rst_n  = '0;
    w_in_en  = '0;
    w_busy   = 1'b1;
    case (w_next_state)
      RST_HOLD: w_clk_en = w_oh;
      RUN: begin
        w_clk_en = w_oh;
        w_rst_n  = w_oh;
        w_in_en  = w_oh;
        w_busy   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= RST_HOLD;
      r_active    <= '0;
      r_target    <= '0;
      r_cnt       <= BOOT_LOAD;
      r_dwell_cnt <= '0;
      r_clk_en    <= NUM_TILES'(onehot(32'd0));
      r_rst_n     <= '0;
      r_in_en     <= '0;
      r_busy      <= 1'b1;
    end else begin
      r_state     <= w_next_state;
      r_active    <= w_next_active;
      r_target    <= w_next_target;
      r_cnt       <= w_next_cnt;
      r_dwell_cnt <= w_next_dwell;
      r_clk_en    <= w_clk_en;
      r_rst_n     <= w_rst_n;
      r_in_en     <= w_in_en;
      r_busy      <= w_busy;
    end
  end

  assign tile_clk_en = r_clk_en;
  assign tile_rst_n  = r_rst_n;
  assign tile_in_en  = r_in_en;
  assign out_sel     = r_active;
  assign busy        = r_busy;

endmodule
